// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU and the
// EX/MEM pipeline register with stall/flush hooks and a retired-instruction counter.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [3:0]  alu_ctrl,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_ovf,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [31:0] out_count
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_LUI = 4'b1110,
        OP_NOR = 4'b1111
    } alu_op_e;

    logic        valid_q, zero_q, ovf_q, reg_write_q, mem_read_q, mem_write_q;
    logic [31:0] result_q, store_q, count_q;
    logic [4:0]  rd_q;

    logic        exm_ok, wb_ok;
    logic [31:0] fwd_rs, fwd_rt, op_a, op_b, sum, diff;
    logic [31:0] result_d;
    logic        ovf_d;

    // A load's EX/MEM result is an address, not data, so it is never forwarded.
    assign exm_ok = valid_q && reg_write_q && !mem_read_q && (rd_q != 5'd0);
    assign wb_ok  = wb_reg_write && (wb_rd != 5'd0);

    assign fwd_rs = (exm_ok && rd_q  == rs_addr) ? result_q :
                    (wb_ok  && wb_rd == rs_addr) ? wb_data  : rs_data;
    assign fwd_rt = (exm_ok && rd_q  == rt_addr) ? result_q :
                    (wb_ok  && wb_rd == rt_addr) ? wb_data  : rt_data;

    assign op_a = fwd_rs;
    assign op_b = alu_src ? imm : fwd_rt;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        result_d = '0;
        ovf_d    = 1'b0;
        case (alu_op_e'(alu_ctrl))
            OP_AND: result_d = op_a & op_b;
            OP_OR:  result_d = op_a | op_b;
            OP_NOR: result_d = ~(op_a | op_b);
            OP_ADD: begin
                result_d = sum;
                ovf_d    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            end
            OP_SUB: begin
                result_d = diff;
                ovf_d    = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            end
            OP_SLT: result_d = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_LUI: result_d = {op_b[15:0], 16'h0000};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all registers sample pre-edge values together.
        if (!rst_n) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            count_q     <= '0;
        end else if (flush) begin
            // Bubble: everything clears except the retire count.
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            result_q    <= result_d;
            zero_q      <= (result_d == 32'd0);
            ovf_q       <= ovf_d;
            store_q     <= fwd_rt;
            rd_q        <= rd_addr;
            reg_write_q <= reg_write && in_valid;
            mem_read_q  <= mem_read && in_valid;
            mem_write_q <= mem_write && in_valid;
            if (in_valid) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_zero       = zero_q;
    assign out_ovf        = ovf_q;
    assign out_store_data = store_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = reg_write_q;
    assign out_mem_read   = mem_read_q;
    assign out_mem_write  = mem_write_q;
    assign out_count      = count_q;

endmodule
